motor_frame_decoder: RTL
========================

MOTOR_FRAME_DECODER -- requirements
Module: motor_frame_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48_000, meaning the maximum idle clock cycles allowed between bytes inside one frame.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port rx_valid, input, 1, one-cycle strobe marking a received UART byte.
REQ-005 SHALL have port rx_data, input, 8, received byte, valid while rx_valid is high.
REQ-006 SHALL have port my_id, input, 8, own motor id; quasi-static.
REQ-007 SHALL have port status_request, output, 1, one-cycle pulse when a valid status request addressed to my_id is decoded.
REQ-008 SHALL have port setpoint_update and control_update, outputs, 1 each, one-cycle pulses marking new decoded values.
REQ-009 SHALL have port setpoint, output, 32 signed, last decoded setpoint.
REQ-010 SHALL have port control_mode, output, 8, plus Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband, outputs, 32 signed each, last decoded control parameters.
REQ-011 SHALL have ports crc_error_count and timeout_count, outputs, 16 each, saturating event counters.

Function
REQ-012 SHALL recognise three frames by 4-byte magic, sent MSB first: status request 0x1CE1CEBB, 7 bytes; setpoint 0xD0D0D0D0, 11 bytes; control mode 0xBAADA555, 34 bytes.
REQ-013 SHALL use this frame layout: bytes 0-3 are the magic; byte 4 is the id; the payload follows; the last 2 bytes are CRC high then low.
REQ-014 SHALL use these payloads, with every 32-bit field MSB first:
- setpoint frame: bytes 5-8 are setpoint.
- control frame: byte 5 is control_mode; bytes 6-29 are Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband; bytes 30-31 are reserved (CRC-covered, not decoded).
REQ-015 SHALL compute the CRC as follows:
- polynomial x^16+x^15+x^2+1;
- init 0xFFFF;
- 8 bits per byte, first serial bit D[7];
- no reflection, no final XOR;
- covers byte 4 through the byte before the CRC.
REQ-016 SHALL implement states HUNT, PAYLOAD and CHECK.
REQ-017 In HUNT, each rx_valid SHALL shift rx_data into a 4-byte window; if the window including the new byte equals a magic, the block SHALL latch the frame type, clear the byte counter, load the CRC with 0xFFFF and enter PAYLOAD.
REQ-018 In PAYLOAD, each rx_valid SHALL store the byte at index counter, advance the CRC for non-CRC bytes, increment the counter and clear the idle timer; after frame_length-4 bytes the block SHALL enter CHECK in the next cycle.
REQ-019 In CHECK (one cycle), the block SHALL compare the computed CRC against the received CRC bytes, then return to HUNT with the window cleared to 0x00000000.
REQ-020 On CRC mismatch, the block SHALL increment crc_error_count, leave all data outputs unchanged and assert no pulse.
REQ-021 On CRC match, the block SHALL act if id==my_id, or if id==0xFF for setpoint/control frames; a status request with id 0xFF, or any frame with another id, SHALL be ignored silently.
REQ-022 On an accepted frame, the block SHALL register the decoded fields and assert the matching pulse for exactly one cycle.
REQ-023 Latency: for the final CRC byte strobed in cycle N, the block SHALL show updated outputs and the pulse in cycle N+2.
REQ-024 Payload bytes SHALL NOT enter the hunt window, so magic patterns inside a payload are never matched.
REQ-025 In PAYLOAD, if the idle timer reaches TIMEOUT_CYCLES without rx_valid, the block SHALL return to HUNT, clear the window, increment timeout_count and apply no outputs.
REQ-026 An rx_valid arriving in the CHECK cycle SHALL be discarded; this is legal because a UART cannot strobe on consecutive cycles.
REQ-027 Both counters SHALL saturate at 0xFFFF and never wrap.
REQ-028 Decoded outputs SHALL hold their value until the next accepted frame of the same type.

Reset
REQ-029 Reset SHALL asynchronously force state HUNT, window 0x00000000, counter 0, CRC 0xFFFF and idle timer 0.
REQ-030 Reset SHALL drive all pulses low and all data outputs and counters to 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release no partial data is applied.

Verification
REQ-032 Bench SHALL cover: my_id=3, setpoint frame id 3, setpoint 0x00001234 with model CRC -> setpoint=0x00001234, setpoint_update high exactly in cycle N+2.
REQ-033 Bench SHALL cover: the same frame with the last CRC byte XORed with 0x01 -> crc_error_count=1, setpoint unchanged, no pulse.
REQ-034 Bench SHALL cover: control frame id 0xFF, Kp=0x00010000, deadband=0xFFFFFFF6, control_mode=2 -> all fields decoded, control_update one pulse; a status request with id 0xFF -> no status_request pulse.
REQ-035 Bench SHALL cover: status request id 3 preceded by junk bytes 0x1C,0xE1 -> status_request pulse once; a request with id 4 -> none.
REQ-036 Bench SHALL cover: TIMEOUT_CYCLES=100, setpoint frame stopped after byte 6 -> timeout_count=1 at idle cycle 100; a complete frame then decodes correctly.
REQ-037 Bench SHALL cover: reset pulsed mid-control-frame, then the remaining bytes sent -> no update, outputs 0; a following valid frame is accepted.

Source files
------------

// File: rtl/motor_frame_decoder.sv
// Motor command frame decoder.
// Hunts a byte stream for one of three magic words, collects the frame body,
// checks its CRC-16 (0x8005, init 0xFFFF, MSB first) and publishes the decoded
// fields when the frame is addressed to this motor.
module motor_frame_decoder #(
    parameter int TIMEOUT_CYCLES = 48_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic [7:0]         my_id,
    output logic               status_request,
    output logic               setpoint_update,
    output logic               control_update,
    output logic signed [31:0] setpoint,
    output logic [7:0]         control_mode,
    output logic signed [31:0] Kp,
    output logic signed [31:0] Ki,
    output logic signed [31:0] Kd,
    output logic signed [31:0] PWMLimit,
    output logic signed [31:0] IntegralLimit,
    output logic signed [31:0] deadband,
    output logic [15:0]        crc_error_count,
    output logic [15:0]        timeout_count
);

    localparam logic [31:0] MAGIC_STATUS   = 32'h1CE1_CEBB;
    localparam logic [31:0] MAGIC_SETPOINT = 32'hD0D0_D0D0;
    localparam logic [31:0] MAGIC_CONTROL  = 32'hBAAD_A555;

    // The idle timer fires on the cycle in which it would reach TIMEOUT_CYCLES.
    localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    typedef enum logic [1:0] {
        FT_STATUS,
        FT_SETPOINT,
        FT_CONTROL
    } frame_t;

    state_t               state;
    frame_t               frame_type;
    frame_t               magic_type;
    logic                 magic_hit;
    logic [31:0]          window;
    logic [31:0]          window_next;
    logic [4:0]           counter;
    logic [4:0]           last_index;
    logic [4:0]           crc_high_index;
    logic [15:0]          crc;
    logic [15:0]          crc_next;
    logic [15:0]          received_crc;
    logic [TIMER_W-1:0]   idle_timer;
    logic [7:0]           payload_buf [0:29];
    logic [7:0]           frame_id;
    logic                 accept_unicast;
    logic                 accept_broadcast;

    // Advance a CRC-16 (x^16+x^15+x^2+1) by one byte, D[7] shifted in first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        logic        feedback;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            feedback = c[15] ^ data[i];
            c        = {c[14:0], 1'b0};
            if (feedback) begin
                c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    assign window_next    = {window[23:0], rx_data};
    assign crc_next       = crc_byte(crc, rx_data);
    assign crc_high_index = last_index - 5'd1;
    assign received_crc   = {payload_buf[crc_high_index], payload_buf[last_index]};
    assign frame_id       = payload_buf[0];

    // A status request must name this motor explicitly; data frames also take broadcast.
    assign accept_unicast   = (frame_id == my_id) && (frame_id != 8'hFF);
    assign accept_broadcast = (frame_id == my_id) || (frame_id == 8'hFF);

    // Classify the window including the incoming byte against the three magics.
    always_comb begin
        magic_hit  = 1'b1;
        magic_type = FT_STATUS;
        case (window_next)
            MAGIC_STATUS:   magic_type = FT_STATUS;
            MAGIC_SETPOINT: magic_type = FT_SETPOINT;
            MAGIC_CONTROL:  magic_type = FT_CONTROL;
            default:        magic_hit  = 1'b0;
        endcase
    end

    // Index of the final body byte (low CRC byte), counted from the id byte.
    always_comb begin
        case (frame_type)
            FT_STATUS:   last_index = 5'd2;
            FT_SETPOINT: last_index = 5'd6;
            default:     last_index = 5'd29;
        endcase
    end

    // Body bytes land here; the buffer carries no reset because nothing reads it before a full frame.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rx_valid) begin
            payload_buf[counter] <= rx_data;
        end
    end

    // Frame FSM: hunt for magic, collect body with idle timeout, check CRC and publish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            frame_type      <= FT_STATUS;
            window          <= 32'h0;
            counter         <= 5'd0;
            crc             <= 16'hFFFF;
            idle_timer      <= '0;
            status_request  <= 1'b0;
            setpoint_update <= 1'b0;
            control_update  <= 1'b0;
            setpoint        <= '0;
            control_mode    <= 8'h0;
            Kp              <= '0;
            Ki              <= '0;
            Kd              <= '0;
            PWMLimit        <= '0;
            IntegralLimit   <= '0;
            deadband        <= '0;
            crc_error_count <= 16'h0;
            timeout_count   <= 16'h0;
        end else begin
            status_request  <= 1'b0;
            setpoint_update <= 1'b0;
            control_update  <= 1'b0;
            case (state)
                HUNT: begin
                    if (rx_valid) begin
                        window <= window_next;
                        if (magic_hit) begin
                            frame_type <= magic_type;
                            counter    <= 5'd0;
                            crc        <= 16'hFFFF;
                            idle_timer <= '0;
                            state      <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        counter    <= counter + 5'd1;
                        idle_timer <= '0;
                        if (counter < crc_high_index) begin
                            crc <= crc_next;
                        end
                        if (counter == last_index) begin
                            state <= CHECK;
                        end
                    end else if (idle_timer == TIMER_LAST) begin
                        state  <= HUNT;
                        window <= 32'h0;
                        if (timeout_count != 16'hFFFF) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
                    end else begin
                        idle_timer <= idle_timer + TIMER_W'(1);
                    end
                end
                CHECK: begin
                    state  <= HUNT;
                    window <= 32'h0;
                    if (crc != received_crc) begin
                        if (crc_error_count != 16'hFFFF) begin
                            crc_error_count <= crc_error_count + 16'd1;
                        end
                    end else begin
                        case (frame_type)
                            FT_STATUS: begin
                                if (accept_unicast) begin
                                    status_request <= 1'b1;
                                end
                            end
                            FT_SETPOINT: begin
                                if (accept_broadcast) begin
                                    setpoint        <= {payload_buf[1], payload_buf[2], payload_buf[3], payload_buf[4]};
                                    setpoint_update <= 1'b1;
                                end
                            end
                            default: begin
                                if (accept_broadcast) begin
                                    control_mode   <= payload_buf[1];
                                    Kp             <= {payload_buf[2],  payload_buf[3],  payload_buf[4],  payload_buf[5]};
                                    Ki             <= {payload_buf[6],  payload_buf[7],  payload_buf[8],  payload_buf[9]};
                                    Kd             <= {payload_buf[10], payload_buf[11], payload_buf[12], payload_buf[13]};
                                    PWMLimit       <= {payload_buf[14], payload_buf[15], payload_buf[16], payload_buf[17]};
                                    IntegralLimit  <= {payload_buf[18], payload_buf[19], payload_buf[20], payload_buf[21]};
                                    deadband       <= {payload_buf[22], payload_buf[23], payload_buf[24], payload_buf[25]};
                                    control_update <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule
